// File: rtl/sync_conditioner.sv
// sync_conditioner
//   Conditions the raw H and V sync pins for the video format detector.
//   Each channel is synchronised, deglitched and polarity-detected, and
//   produces a clean active-high sync level, a leading-edge strobe and a
//   presence flag. Both channels share one implementation and differ only
//   in their idle timeout.
//
// Ports
//   clk_50mhz_in  in   system clock, rising edge
//   reset         in   asynchronous, active-high, clears all state
//   hsync_in      in   raw hsync, asynchronous, either polarity
//   vsync_in      in   raw vsync, asynchronous, either polarity
//   hsync_out     out  conditioned hsync, 1 = sync active
//   vsync_out     out  conditioned vsync, 1 = sync active
//   hsync_strobe  out  one-cycle pulse on the hsync_out 0->1 edge
//   vsync_strobe  out  one-cycle pulse on the vsync_out 0->1 edge
//   hsync_pol     out  detected raw hsync polarity, 1 = active-high
//   vsync_pol     out  detected raw vsync polarity, 1 = active-high
//   h_present     out  hsync toggling within H_TIMEOUT
//   v_present     out  vsync toggling within V_TIMEOUT

// One sync channel: synchroniser, run-length filter, period measurement,
// presence tracking, polarity detection and registered outputs.
module sync_conditioner_chan #(
  parameter int FILTER_LEN = 4,
  parameter int CNT_W      = 24,
  parameter int TIMEOUT    = 2500
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic strobe,
  output logic pol,
  output logic present
);

  localparam int RC_W = $clog2(FILTER_LEN) + 1;
  localparam logic [RC_W-1:0]  RC_ZERO  = {RC_W{1'b0}};
  localparam logic [RC_W-1:0]  RC_ONE   = {{(RC_W-1){1'b0}}, 1'b1};
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] IC_LAST  = CNT_W'(TIMEOUT - 1);

  logic             s1_r, s2_r, f_r, f_d_r;
  logic [RC_W-1:0]  rc_r;
  logic [CNT_W-1:0] hi_cnt_r, lo_cnt_r, ic_r;
  logic             armed_r, present_r, pol_r, out_r, strobe_r;

  logic             f_upd_s, f_nxt_s, rise_s, edge_s, timeout_s;
  logic [RC_W-1:0]  rc_nxt_s;
  logic [CNT_W-1:0] hi_nxt_s, lo_nxt_s, ic_nxt_s;
  logic             armed_nxt_s, present_nxt_s, pol_nxt_s, out_nxt_s, strobe_nxt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // rise/edge are seen one cycle after f changes, aligned with the output update
  assign rise_s = f_r & ~f_d_r;
  assign edge_s = f_r ^ f_d_r;

  // Run-length filter: accept a new level after FILTER_LEN consecutive samples
  always_comb begin
    f_upd_s  = 1'b0;
    f_nxt_s  = f_r;
    rc_nxt_s = RC_ZERO;
    if (s2_r == f_r) begin
      rc_nxt_s = RC_ZERO;
    end else if (rc_r == RC_LAST) begin
      f_upd_s  = 1'b1;
      f_nxt_s  = s2_r;
      rc_nxt_s = RC_ZERO;
    end else begin
      rc_nxt_s = rc_r + RC_ONE;
    end
  end

  // High/low portion counters; the rise cycle already belongs to the new high portion
  always_comb begin
    hi_nxt_s = hi_cnt_r;
    lo_nxt_s = lo_cnt_r;
    if (rise_s) begin
      hi_nxt_s = CNT_ONE;
      lo_nxt_s = CNT_ZERO;
    end else if (f_r) begin
      hi_nxt_s = sat_inc(hi_cnt_r);
    end else begin
      lo_nxt_s = sat_inc(lo_cnt_r);
    end
  end

  // Idle counter and presence tracking; idle time is counted from the edge where f changes
  always_comb begin
    ic_nxt_s      = ic_r;
    armed_nxt_s   = armed_r;
    present_nxt_s = present_r;
    timeout_s     = ~f_upd_s & (ic_r == IC_LAST);
    if (f_upd_s) begin
      ic_nxt_s = CNT_ZERO;
    end else begin
      ic_nxt_s = sat_inc(ic_r);
    end
    if (timeout_s) begin
      present_nxt_s = 1'b0;
      armed_nxt_s   = 1'b0;
    end else if (rise_s && !present_r) begin
      if (armed_r) begin
        present_nxt_s = 1'b1;
        armed_nxt_s   = 1'b0;
      end else begin
        armed_nxt_s = 1'b1;
      end
    end else begin
      armed_nxt_s = armed_r;
    end
  end

  // Polarity from the measured period: the shorter portion is the sync pulse
  always_comb begin
    pol_nxt_s = pol_r;
    if (rise_s && present_nxt_s) begin
      if (hi_cnt_r < lo_cnt_r) begin
        pol_nxt_s = 1'b1;
      end else if (hi_cnt_r > lo_cnt_r) begin
        pol_nxt_s = 1'b0;
      end else begin
        pol_nxt_s = pol_r;
      end
    end else begin
      pol_nxt_s = pol_r;
    end
  end

  // Output level from the updated pol/present; strobe only on f-driven 0->1
  always_comb begin
    out_nxt_s    = present_nxt_s & (pol_nxt_s ? f_r : ~f_r);
    strobe_nxt_s = edge_s & out_nxt_s & ~out_r;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r      <= 1'b0;
      s2_r      <= 1'b0;
      f_r       <= 1'b0;
      f_d_r     <= 1'b0;
      rc_r      <= RC_ZERO;
      hi_cnt_r  <= CNT_ZERO;
      lo_cnt_r  <= CNT_ZERO;
      ic_r      <= CNT_ZERO;
      armed_r   <= 1'b0;
      present_r <= 1'b0;
      pol_r     <= 1'b0;
      out_r     <= 1'b0;
      strobe_r  <= 1'b0;
    end else begin
      s1_r      <= raw;
      s2_r      <= s1_r;
      f_r       <= f_nxt_s;
      f_d_r     <= f_r;
      rc_r      <= rc_nxt_s;
      hi_cnt_r  <= hi_nxt_s;
      lo_cnt_r  <= lo_nxt_s;
      ic_r      <= ic_nxt_s;
      armed_r   <= armed_nxt_s;
      present_r <= present_nxt_s;
      pol_r     <= pol_nxt_s;
      out_r     <= out_nxt_s;
      strobe_r  <= strobe_nxt_s;
    end
  end

  assign level   = out_r;
  assign strobe  = strobe_r;
  assign pol     = pol_r;
  assign present = present_r;

endmodule

module sync_conditioner #(
  parameter int FILTER_LEN = 4,
  parameter int CNT_W      = 24,
  parameter int H_TIMEOUT  = 2500,
  parameter int V_TIMEOUT  = 2500000
) (
  input  logic clk_50mhz_in,
  input  logic reset,
  input  logic hsync_in,
  input  logic vsync_in,
  output logic hsync_out,
  output logic vsync_out,
  output logic hsync_strobe,
  output logic vsync_strobe,
  output logic hsync_pol,
  output logic vsync_pol,
  output logic h_present,
  output logic v_present
);

  sync_conditioner_chan #(
    .FILTER_LEN (FILTER_LEN),
    .CNT_W      (CNT_W),
    .TIMEOUT    (H_TIMEOUT)
  ) u_h (
    .clk     (clk_50mhz_in),
    .reset   (reset),
    .raw     (hsync_in),
    .level   (hsync_out),
    .strobe  (hsync_strobe),
    .pol     (hsync_pol),
    .present (h_present)
  );

  sync_conditioner_chan #(
    .FILTER_LEN (FILTER_LEN),
    .CNT_W      (CNT_W),
    .TIMEOUT    (V_TIMEOUT)
  ) u_v (
    .clk     (clk_50mhz_in),
    .reset   (reset),
    .raw     (vsync_in),
    .level   (vsync_out),
    .strobe  (vsync_strobe),
    .pol     (vsync_pol),
    .present (v_present)
  );

endmodule

// File: doc/sync_conditioner.md
# sync_conditioner

Front-end stage between the raw H/V sync pins and the video format detector on the 50 MHz clock. Each sync input is synchronised, deglitched, and polarity-detected. The block then emits clean active-high sync levels, one-cycle leading-edge strobes, and per-channel presence flags. The format detector and the sync pass-through outputs consume these instead of the raw pins.

## Interface
- FILTER_LEN, 4: consecutive identical synchronised samples required to accept a level change (≥2)
- CNT_W, 24: width of the period and idle counters
- H_TIMEOUT, 2500: idle cycles without an hsync edge before h_present drops (50 µs)
- V_TIMEOUT, 2500000: idle cycles without a vsync edge before v_present drops (50 ms)

- clk_50mhz_in  in  1  system clock, 50 MHz; all state on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- hsync_in  in  1  raw hsync, asynchronous, either polarity
- vsync_in  in  1  raw vsync, asynchronous, either polarity
- hsync_out  out  1  conditioned hsync, 1 = sync active
- vsync_out  out  1  conditioned vsync, 1 = sync active
- hsync_strobe  out  1  one-cycle pulse on the hsync_out 0→1 edge
- vsync_strobe  out  1  one-cycle pulse on the vsync_out 0→1 edge
- hsync_pol  out  1  detected raw polarity: 1 = active-high, 0 = active-low
- vsync_pol  out  1  as hsync_pol, for vsync
- h_present  out  1  hsync toggling within H_TIMEOUT
- v_present  out  1  vsync toggling within V_TIMEOUT

## Operation
The H and V channels are identical and independent; they differ only in their TIMEOUT parameter.
- **Synchroniser:** two flops s1→s2, reset 0.
- **Filter:**
  - Register f holds the filtered level; run counter rc.
  - If s2 == f, rc ← 0.
  - Otherwise rc increments; when rc reaches FILTER_LEN−1 with s2 still ≠ f, f ← s2 and rc ← 0.
  - Reset: f = 0, rc = 0.
- **Edge detect:** rise = f goes 0→1; edge = any f change.
- **Period measure:**
  - hi_cnt and lo_cnt count cycles with f = 1 and f = 0 respectively.
  - Both saturate at 2^CNT_W−1 and clear on rise.
- **Presence:**
  - Idle counter ic clears on edge; otherwise it increments, saturating.
  - present ← 0 when ic reaches TIMEOUT.
  - armed ← 1 on a rise while present = 0.
  - present ← 1 on the next rise after armed, provided no timeout occurred in between. armed clears on timeout.
- **Polarity:**
  - On a rise with present = 1 (a full period measured): pol ← 1 if hi_cnt < lo_cnt, pol ← 0 if hi_cnt > lo_cnt.
  - If hi_cnt == lo_cnt, pol is unchanged.
  - pol is retained through loss of presence.
- **Output (registered):** out ← present & (pol ? f : ~f), computed from the updated pol/present values.
- **Strobe:** strobe ← 1 for exactly one cycle when out goes 0→1 because of an f edge. Out transitions caused only by a pol or present change do not strobe.
- **Reset values:** every output is 0 (out, strobe, pol, present).
- **Reset mid-operation:** all state clears immediately. Re-acquisition needs two rises after release.

## Timing
- **Raw to out latency:** a raw level held stable from clock edge k propagates as follows.
  - s2 is valid at k+1.
  - f updates at k+FILTER_LEN+1.
  - out and strobe update at k+FILTER_LEN+2.
- **Glitch rejection:** a raw pulse shorter than FILTER_LEN cycles never changes f.
- **Presence drop:** present falls exactly TIMEOUT cycles after the last f edge. out falls in the same cycle.
- **Presence acquire:** present rises on the second rise after reset or loss. The pol update and out take effect in that same cycle.
- **Equal high and low portions (50% duty):** pol holds its previous value.
- **Counter saturation:** hi_cnt and lo_cnt never wrap; at saturation the comparison uses the saturated values.

## Test plan
- **Reset:** assert reset while hsync_in toggles → all outputs 0 during reset. After release, h_present stays 0 until the second filtered rise.
- **Glitch:** FILTER_LEN = 4, hsync_in steady low with a 3-cycle high pulse → f, hsync_out and hsync_strobe unchanged. A 4-cycle pulse → f rises at k+5.
- **Active-low hsync:** period 3200 cycles, low for 188 → after 2 rises h_present = 1 and hsync_pol = 0. hsync_out is high for 188 cycles per line, and hsync_strobe fires once per line at FILTER_LEN+2 cycles after the raw falling edge.
- **Active-high vsync:** V_TIMEOUT overridden to 5000, period 4000, high for 100 → vsync_pol = 1, vsync_out high for 100 cycles, one vsync_strobe per frame.
- **Loss:** H_TIMEOUT = 2500, stop hsync after lock → h_present and hsync_out fall exactly 2500 cycles after the last f edge, and hsync_pol is retained. Restart → h_present returns on the second rise.
- **Polarity flip mid-stream:** switch hsync from active-low to active-high → hsync_pol updates on the first full measured period. No strobe is generated by the polarity change itself.
